// File: rtl/spu_stream_arbiter.sv
// Round-robin packet arbiter: N requester streams share one registered output toward the SPU.
// A grant is held for a whole packet; a new grant is chosen only after the granted port's last beat is accepted.
module spu_stream_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int PORT_BITS  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [N_PORTS-1:0]            s_valid,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [N_PORTS-1:0]            s_last,
  output logic [N_PORTS-1:0]            s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [PORT_BITS-1:0]          m_port,
  input  logic                          m_ready,
  output logic                          busy,
  output logic [15:0]                   pkt_count
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                  state_q, state_d;
  logic [PORT_BITS-1:0]    grant_idx_q, grant_idx_d;
  logic [PORT_BITS-1:0]    last_idx_q, last_idx_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic [PORT_BITS-1:0]    m_port_q, m_port_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  logic [DATA_WIDTH-1:0]   s_data_arr [N_PORTS];
  logic                    rr_found;
  logic [PORT_BITS-1:0]    rr_idx;
  logic [PORT_BITS-1:0]    cand;
  logic                    out_free;
  logic                    accept;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign s_data_arr[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search upward from the port after the last winner, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = PORT_BITS'((int'(last_idx_q) + k) % N_PORTS);
      if (!rr_found && s_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign out_free = !m_valid_q || m_ready;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    s_ready     = '0;
    accept      = 1'b0;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_port_d    = m_port_q;
    pkt_count_d = pkt_count_q;

    case (state_q)
      IDLE: begin
        if (enable && rr_found) begin
          state_d     = GRANT;
          grant_idx_d = rr_idx;
        end
      end
      GRANT: begin
        s_ready[grant_idx_q] = out_free;
        accept = s_valid[grant_idx_q] && out_free;
        // enable is deliberately ignored here so a started packet always completes.
        if (accept && s_last[grant_idx_q]) begin
          state_d    = IDLE;
          last_idx_d = grant_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_arr[grant_idx_q];
      m_last_d  = s_last[grant_idx_q];
      m_port_d  = grant_idx_q;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (m_valid_q && m_ready && m_last_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= PORT_BITS'(N_PORTS - 1);
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_port_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_port_q    <= m_port_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_port    = m_port_q;
  assign busy      = (state_q == GRANT);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_spu_stream_arbiter.sv
// Directed bench for spu_stream_arbiter: reset, single packet, round robin, no interleave,
// backpressure, enable gating and mid-packet reset, with hand-computed expectations.
module tb_spu_stream_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int PB = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [NP-1:0]     s_valid;
  logic [NP*DW-1:0]  s_data;
  logic [NP-1:0]     s_last;
  logic [NP-1:0]     s_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic              m_last;
  logic [PB-1:0]     m_port;
  logic              m_ready;
  logic              busy;
  logic [15:0]       pkt_count;

  int vectors = 0;
  int miscompares = 0;

  spu_stream_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .PORT_BITS(PB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_port(m_port),
    .m_ready(m_ready), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    s_valid[p] = v;
    s_data[p*DW +: DW] = d;
    s_last[p] = l;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    s_valid = '0; s_last = '0; s_data = '0;
    m_ready = 1'b1; enable = 1'b1;
    cyc; cyc;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
    s_valid = '1; s_last = '1; s_data = '1;
    cyc; cyc; #1;
    vectors++; if ({m_valid, m_last, m_port, busy} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want %b", {m_valid, m_last, m_port, busy}, 5'b0); end
    vectors++; if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_s_ready: got %b want 0000", s_ready); end
    vectors++; if (m_data !== 64'h0) begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    vectors++; if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    s_valid = '0; s_last = '0; s_data = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    drive(0, 1'b1, 64'd1, 1'b0); #1;
    vectors++; if ({busy, s_ready} !== 5'b0_0000) begin miscompares++; $display("FAIL single_c0_idle: got %b want 00000", {busy, s_ready}); end
    cyc;
    vectors++; if ({busy, s_ready} !== 5'b1_0001) begin miscompares++; $display("FAIL single_c1_grant: got %b want 10001", {busy, s_ready}); end
    cyc; drive(0, 1'b1, 64'd2, 1'b0); #1;
    vectors++; if ({m_valid, m_last, m_port} !== 4'b1000) begin miscompares++; $display("FAIL single_c2_ctrl: got %b want 1000", {m_valid, m_last, m_port}); end
    vectors++; if (m_data !== 64'd1) begin miscompares++; $display("FAIL single_c2_data: got %h want 1", m_data); end
    cyc; drive(0, 1'b1, 64'd3, 1'b1); #1;
    vectors++; if ({m_valid, m_last, m_port} !== 4'b1000) begin miscompares++; $display("FAIL single_c3_ctrl: got %b want 1000", {m_valid, m_last, m_port}); end
    vectors++; if (m_data !== 64'd2) begin miscompares++; $display("FAIL single_c3_data: got %h want 2", m_data); end
    cyc; drive(0, 1'b0, 64'd0, 1'b0); #1;
    vectors++; if ({m_valid, m_last, m_port, busy} !== 5'b11000) begin miscompares++; $display("FAIL single_c4_ctrl: got %b want 11000", {m_valid, m_last, m_port, busy}); end
    vectors++; if (m_data !== 64'd3) begin miscompares++; $display("FAIL single_c4_data: got %h want 3", m_data); end
    vectors++; if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL single_c4_pkt: got %0d want 0", pkt_count); end
    cyc;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_c5_mvalid: got %b want 0", m_valid); end
    vectors++; if (pkt_count !== 16'd1) begin miscompares++; $display("FAIL single_c5_pkt: got %0d want 1", pkt_count); end
  endtask

  task automatic test_round_robin;
    logic [PB-1:0] gp [5];
    logic [DW-1:0] gd [5];
    logic [PB-1:0] ep;
    int n;
    do_reset;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, DW'(16 + p), 1'b1);
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc;
      if (m_valid && n < 5) begin gp[n] = m_port; gd[n] = m_data; n++; end
      if (c == 10) s_valid = '0;
    end
    cyc;
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL rr_beat_count: got %0d want 5", n); end
    for (int i = 0; i < 5; i++) begin
      ep = PB'(i % NP);
      vectors++; if (gp[i] !== ep) begin miscompares++; $display("FAIL rr_port[%0d]: got %0d want %0d", i, gp[i], ep); end
      vectors++; if (gd[i] !== DW'(16 + (i % NP))) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", i, gd[i], DW'(16 + (i % NP))); end
    end
    vectors++; if (pkt_count !== 16'd5) begin miscompares++; $display("FAIL rr_pkt: got %0d want 5", pkt_count); end
  endtask

  task automatic test_no_interleave;
    logic [PB-1:0] ep [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
    logic [7:0]    ed [4] = '{8'h21, 8'h22, 8'h23, 8'h11};
    logic          el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [PB-1:0] gp [8];
    logic [DW-1:0] gd [8];
    logic          gl [8];
    int n;
    n = 0;
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0: drive(2, 1'b1, 64'h21, 1'b0);
        1: drive(1, 1'b1, 64'h11, 1'b1);
        2: drive(2, 1'b1, 64'h22, 1'b0);
        3: drive(2, 1'b1, 64'h23, 1'b1);
        4: drive(2, 1'b0, 64'h0, 1'b0);
        6: drive(1, 1'b0, 64'h0, 1'b0);
        default: ;
      endcase
      #1;
      if (m_valid && n < 8) begin gp[n] = m_port; gd[n] = m_data; gl[n] = m_last; n++; end
      if (c == 1) begin
        vectors++; if (s_ready !== 4'b0100) begin miscompares++; $display("FAIL noint_c1_ready: got %b want 0100", s_ready); end
      end
      if (c == 5) begin
        vectors++; if (s_ready !== 4'b0010) begin miscompares++; $display("FAIL noint_c5_ready: got %b want 0010", s_ready); end
      end
      cyc;
    end
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL noint_beat_count: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({gp[i], gl[i], gd[i]} !== {ep[i], el[i], 56'h0, ed[i]}) begin miscompares++; $display("FAIL noint_beat[%0d]: got port %0d last %b data %h want port %0d last %b data %h", i, gp[i], gl[i], gd[i], ep[i], el[i], ed[i]); end
    end
    vectors++; if (pkt_count !== 16'd7) begin miscompares++; $display("FAIL noint_pkt: got %0d want 7", pkt_count); end
  endtask

  task automatic test_backpressure;
    drive(3, 1'b1, 64'h31, 1'b0); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_c0_busy: got %b want 0", busy); end
    cyc;
    vectors++; if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_c1_ready: got %b want 1000", s_ready); end
    cyc; drive(3, 1'b1, 64'h32, 1'b0); #1;
    vectors++; if ({m_valid, m_port, m_data} !== {1'b1, 2'd3, 64'h31}) begin miscompares++; $display("FAIL bp_c2_beat: got v%b p%0d d%h want v1 p3 d31", m_valid, m_port, m_data); end
    cyc;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin drive(3, 1'b1, 64'h33, 1'b1); m_ready = 1'b0; end
      #1;
      vectors++; if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 64'h32}) begin miscompares++; $display("FAIL bp_hold[%0d]: got v%b l%b d%h want v1 l0 d32", k, m_valid, m_last, m_data); end
      vectors++; if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", k, s_ready); end
      cyc;
    end
    m_ready = 1'b1; #1;
    vectors++; if ({m_valid, m_data, s_ready} !== {1'b1, 64'h32, 4'b1000}) begin miscompares++; $display("FAIL bp_release: got v%b d%h r%b want v1 d32 r1000", m_valid, m_data, s_ready); end
    cyc; drive(3, 1'b0, 64'h0, 1'b0); #1;
    vectors++; if ({m_valid, m_last, m_port, busy} !== 5'b11110) begin miscompares++; $display("FAIL bp_last_ctrl: got %b want 11110", {m_valid, m_last, m_port, busy}); end
    vectors++; if (m_data !== 64'h33) begin miscompares++; $display("FAIL bp_last_data: got %h want 33", m_data); end
    cyc;
    vectors++; if ({m_valid, pkt_count} !== {1'b0, 16'd8}) begin miscompares++; $display("FAIL bp_done: got v%b pkt %0d want v0 pkt 8", m_valid, pkt_count); end
  endtask

  task automatic test_enable;
    enable = 1'b1;
    drive(1, 1'b1, 64'h41, 1'b0);
    cyc;
    enable = 1'b0;
    drive(0, 1'b1, 64'h01, 1'b1);
    drive(2, 1'b1, 64'h51, 1'b1);
    #1;
    vectors++; if ({busy, s_ready} !== 5'b1_0010) begin miscompares++; $display("FAIL en_c1_grant: got %b want 10010", {busy, s_ready}); end
    cyc; drive(1, 1'b1, 64'h42, 1'b1); #1;
    vectors++; if ({m_port, m_data} !== {2'd1, 64'h41}) begin miscompares++; $display("FAIL en_c2_beat: got p%0d d%h want p1 d41", m_port, m_data); end
    cyc; drive(1, 1'b0, 64'h0, 1'b0); #1;
    vectors++; if ({m_valid, m_last, m_port, busy, m_data} !== {1'b1, 1'b1, 2'd1, 1'b0, 64'h42}) begin miscompares++; $display("FAIL en_c3_last: got v%b l%b p%0d b%b d%h want v1 l1 p1 b0 d42", m_valid, m_last, m_port, busy, m_data); end
    for (int c = 4; c <= 6; c++) begin
      cyc;
      vectors++; if ({busy, s_ready} !== 5'b0_0000) begin miscompares++; $display("FAIL en_gated_c%0d: got %b want 00000", c, {busy, s_ready}); end
    end
    enable = 1'b1;
    cyc;
    vectors++; if ({busy, s_ready} !== 5'b1_0100) begin miscompares++; $display("FAIL en_resume: got %b want 10100", {busy, s_ready}); end
    cyc; drive(2, 1'b0, 64'h0, 1'b0); #1;
    vectors++; if ({m_valid, m_last, m_port, m_data} !== {1'b1, 1'b1, 2'd2, 64'h51}) begin miscompares++; $display("FAIL en_port2_beat: got v%b l%b p%0d d%h want v1 l1 p2 d51", m_valid, m_last, m_port, m_data); end
    cyc;
    vectors++; if ({busy, s_ready} !== 5'b1_0001) begin miscompares++; $display("FAIL en_port0_grant: got %b want 10001", {busy, s_ready}); end
    cyc; drive(0, 1'b0, 64'h0, 1'b0); #1;
    vectors++; if ({m_valid, m_port, m_data} !== {1'b1, 2'd0, 64'h01}) begin miscompares++; $display("FAIL en_port0_beat: got v%b p%0d d%h want v1 p0 d01", m_valid, m_port, m_data); end
    cyc;
    vectors++; if (pkt_count !== 16'd11) begin miscompares++; $display("FAIL en_pkt: got %0d want 11", pkt_count); end
  endtask

  task automatic test_reset_mid_packet;
    drive(3, 1'b1, 64'h61, 1'b0);
    cyc;
    vectors++; if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL rstmid_c1_ready: got %b want 1000", s_ready); end
    cyc; drive(3, 1'b1, 64'h62, 1'b0); #1;
    vectors++; if ({m_valid, m_port, m_data} !== {1'b1, 2'd3, 64'h61}) begin miscompares++; $display("FAIL rstmid_c2_beat: got v%b p%0d d%h want v1 p3 d61", m_valid, m_port, m_data); end
    reset_n = 1'b0; #1;
    vectors++; if ({m_valid, m_last, m_port, busy, s_ready} !== 9'b0) begin miscompares++; $display("FAIL rstmid_ctrl: got %b want 000000000", {m_valid, m_last, m_port, busy, s_ready}); end
    vectors++; if ({m_data, pkt_count} !== {64'h0, 16'd0}) begin miscompares++; $display("FAIL rstmid_data: got d%h pkt %0d want d0 pkt 0", m_data, pkt_count); end
    cyc;
    reset_n = 1'b1;
    drive(1, 1'b1, 64'h71, 1'b1);
    drive(3, 1'b1, 64'h63, 1'b1);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_release_busy: got %b want 0", busy); end
    cyc;
    vectors++; if ({busy, s_ready} !== 5'b1_0010) begin miscompares++; $display("FAIL rstmid_regrant: got %b want 10010", {busy, s_ready}); end
    cyc; drive(1, 1'b0, 64'h0, 1'b0); #1;
    vectors++; if ({m_valid, m_last, m_port, m_data} !== {1'b1, 1'b1, 2'd1, 64'h71}) begin miscompares++; $display("FAIL rstmid_port1_beat: got v%b l%b p%0d d%h want v1 l1 p1 d71", m_valid, m_last, m_port, m_data); end
    cyc;
    vectors++; if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL rstmid_port3_grant: got %b want 1000", s_ready); end
    cyc; drive(3, 1'b0, 64'h0, 1'b0); #1;
    vectors++; if ({m_port, m_data} !== {2'd3, 64'h63}) begin miscompares++; $display("FAIL rstmid_port3_beat: got p%0d d%h want p3 d63", m_port, m_data); end
    cyc;
    vectors++; if (pkt_count !== 16'd2) begin miscompares++; $display("FAIL rstmid_pkt: got %0d want 2", pkt_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_no_interleave;
    test_backpressure;
    test_enable;
    test_reset_mid_packet;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/spu_stream_arbiter.md
SPU_STREAM_ARBITER -- requirements
Module: spu_stream_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4: number of requester streams sharing the stream processing unit input, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 64: beat data width in bits.
REQ-003 Parameter PORT_BITS, default 2: width of the port index, equal to clog2(N_PORTS).
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high allows new grants; low blocks new grants while the current packet completes.
REQ-007 s_valid  input  N_PORTS  per-port beat valid.
REQ-008 s_data  input  N_PORTS*DATA_WIDTH  per-port beat data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_last  input  N_PORTS  per-port end-of-packet flag.
REQ-010 s_ready  output  N_PORTS  per-port beat accept.
REQ-011 m_valid  output  1  beat valid toward the stream processing unit.
REQ-012 m_data  output  DATA_WIDTH  beat data.
REQ-013 m_last  output  1  end-of-packet flag.
REQ-014 m_port  output  PORT_BITS  source port index of the current beat.
REQ-015 m_ready  input  1  downstream accept.
REQ-016 busy  output  1  high while in state GRANT.
REQ-017 pkt_count  output  16  count of packets fully forwarded; wraps from 0xFFFF to 0.

Function
REQ-018 A beat is transferred on any interface in a cycle where valid and ready are both high.
REQ-019 The block has two states: IDLE and GRANT.
- IDLE: no port granted; all s_ready low.
- GRANT: exactly one port, grant_idx, is granted.
REQ-020 IDLE to GRANT: occurs when enable=1 and any s_valid bit is high. grant_idx is the first requesting port found by searching upward from last_idx+1 modulo N_PORTS (round robin).
REQ-021 In IDLE with enable=0 or no s_valid bits high, the block remains in IDLE.
REQ-022 In GRANT, s_ready[grant_idx] = (!m_valid || m_ready); all other s_ready bits are 0.
REQ-023 The output stage is a single register with one-cycle latency. An accepted beat appears on m_valid, m_data, m_last and m_port in the next cycle.
REQ-024 Output register update rules:
- If a beat is accepted, the output loads the new beat.
- Else, if m_ready=1, m_valid clears to 0.
- Otherwise the output holds (stable under backpressure).
REQ-025 GRANT to IDLE: occurs in the cycle after a beat with s_last=1 is accepted from grant_idx. In that same transition, last_idx is loaded with grant_idx.
REQ-026 A grant is never switched mid-packet. enable=0 during GRANT does not abort the packet.
REQ-027 Arbitration costs one cycle. The earliest first-beat accept is the cycle after IDLE sees s_valid, so the first m_valid occurs two cycles after s_valid.
REQ-028 pkt_count increments by 1 in the cycle in which m_valid, m_ready and m_last are all high.
REQ-029 m_port equals the grant_idx in force when the beat was accepted.
REQ-030 s_valid deasserting mid-packet on the granted port stalls the stream without releasing the grant.

Reset
REQ-031 While reset_n=0, outputs and state take these values:
- state = IDLE
- m_valid = 0, m_last = 0
- m_data = 0, m_port = 0
- s_ready = 0
- busy = 0, pkt_count = 0
- last_idx = N_PORTS-1, so port 0 has first priority.
REQ-032 Reset asserted mid-packet discards the in-flight beat and the grant immediately. After reset_n deasserts, arbitration restarts from port 0 priority.

Verification
REQ-033 Single port: port 0 sends a 3-beat packet (data 1,2,3) with m_ready=1.
- Response: m_valid high on cycles 2..4, m_port=0, m_last only on data 3, pkt_count=1.
REQ-034 Round robin: all four ports hold 1-beat packets continuously.
- Response: m_port sequence is 0,1,2,3,0.
REQ-035 No interleaving: port 2 is mid-packet while port 1 requests.
- Response: all port-2 beats through last are forwarded before any port-1 beat; m_port never interleaves.
REQ-036 Backpressure: m_ready=0 for 5 cycles mid-packet.
- Response: m_data, m_last and m_valid stay stable, s_ready[grant_idx]=0, and no beat is lost or duplicated.
REQ-037 Enable gating: enable drops during a port-1 packet.
- Response: the packet completes, the block stays in IDLE with busy=0 while other ports request, and grants resume 1 cycle after enable=1.
REQ-038 Reset mid-packet: reset_n pulses low during beat 2 of a port-3 packet.
- Response: all outputs return to their reset values at once, and the next grant goes to the lowest requesting port.
